// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, horizontal/vertical counters and
// registered coordinate, blanking, sync and line/frame marker outputs.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] coord_x,
  output logic [9:0] coord_y,
  output logic       active_area,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Decode bounds are one bit wider so a sync interval ending exactly at
  // a total of 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [9:0]       coord_x_q, coord_x_d;
  logic [9:0]       coord_y_q, coord_y_d;
  logic             active_area_q, active_area_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic        pix_en_w;
  logic [10:0] h_ext, v_ext;
  logic        in_h_act, in_v_act, in_hs, in_vs;

  assign pix_en_w = (div_cnt_q == DIV_LAST);

  // Counter advance: divider every clk, raster counters on pixel enables.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    div_cnt_d = div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en_w) begin
      div_cnt_d = '0;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  assign h_ext    = {1'b0, h_cnt_q};
  assign v_ext    = {1'b0, v_cnt_q};
  assign in_h_act = (h_ext < H_ACT_END);
  assign in_v_act = (v_ext < V_ACT_END);
  assign in_hs    = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
  assign in_vs    = (v_ext >= VS_BEGIN) && (v_ext < VS_END);

  // Output registers capture the decode of the pre-advance counters and
  // then hold for a whole pixel period.
  always_comb begin
    coord_x_d     = coord_x_q;
    coord_y_d     = coord_y_q;
    active_area_d = active_area_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (pix_en_w) begin
      coord_x_d     = h_cnt_q;
      coord_y_d     = v_cnt_q;
      active_area_d = in_h_act && in_v_act;
      hsync_d       = in_hs ? SYNC_POL : ~SYNC_POL;
      vsync_d       = in_vs ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_q == 10'd0);
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      coord_x_q     <= '0;
      coord_y_q     <= '0;
      active_area_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      coord_x_q     <= coord_x_d;
      coord_y_q     <= coord_y_d;
      active_area_q <= active_area_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_w;
  assign coord_x     = coord_x_q;
  assign coord_y     = coord_y_q;
  assign active_area = active_area_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces the VGA raster timing that drives the pixel-generation logic and the monitor connector.
- Divides clk into a pixel-rate enable.
- Runs horizontal and vertical counters over the full frame, including the porches and sync intervals.
- Outputs registered coord_x, coord_y and active_area for the graphics block, plus hsync/vsync for the display and line/frame markers for animation logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (>=1); 2 gives 25 MHz pixels from 50 MHz clk
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low, per 640x480@60)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
pix_en  out  1  pixel-rate enable, one clk wide, every CLK_DIV clks
coord_x  out  10  horizontal pixel counter value, 0..H_TOTAL-1
coord_y  out  10  vertical line counter value, 0..V_TOTAL-1
active_area  out  1  high when coord_x<H_ACTIVE and coord_y<V_ACTIVE
hsync  out  1  horizontal sync at SYNC_POL level while asserted
vsync  out  1  vertical sync at SYNC_POL level while asserted
line_start  out  1  high for the pixel period where coord_x==0
frame_start  out  1  high for the pixel period where coord_x==0 and coord_y==0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Both totals must be <=1024. Out-of-range values are a configuration error; the RTL does not check them.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt==CLK_DIV-1), decoded from the register. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Internal counters h_cnt and v_cnt change only on clk edges where pix_en=1.
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Output registers load only on pix_en edges, then hold for CLK_DIV clks. On each such edge they load the decode of the current (h_cnt, v_cnt) while the counters advance:
  - coord_x = h_cnt; coord_y = v_cnt
  - active_area = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL
  - vsync is a function of v_cnt only and changes together with coord_x returning to 0.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0)
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0
  - coord_x=0, coord_y=0, active_area=0, line_start=0, frame_start=0
  - hsync=~SYNC_POL, vsync=~SYNC_POL
- Latency after reset deassert: the first pix_en edge is clk edge CLK_DIV. It loads coord (0,0) with active_area=1, line_start=1, frame_start=1.
- Every output except pix_en is registered, with no combinational path from counters to pins.
- Downstream blocks register rgb one clk after these outputs. That delay is within one pixel for CLK_DIV>=2 and is acceptable.
- Reset mid-frame:
  - All state returns to the reset values immediately (asynchronous).
  - The next frame starts from (0,0) with no partial-line output.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks = 840000 at defaults.

Test Plan:
- Reset release, defaults -> pix_en first at clk edge 2. Outputs then show coord_x=0, coord_y=0, active_area=1, line_start=1, frame_start=1. line_start and frame_start drop 2 clks later, when coord_x=1.
- Free-run one line, defaults -> hsync low for exactly 192 clks, starting when coord_x=656. hsync period 1600 clks. active_area high 1280 clks per visible line.
- Free-run one frame, defaults -> vsync low for 3200 clks, during coord_y=490..491. frame_start rises every 840000 clks. coord_y reaches a maximum of 524 and coord_x a maximum of 799, then both wrap to 0.
- Line 479 to 480 boundary -> active_area is never high while coord_y>=480. coord_x holds 639 with active_area=1, then goes to 640 with active_area=0.
- Reset asserted mid-frame (e.g. at coord 300,200), held 3 clks, released -> outputs return to reset values at once. The first pix_en after release loads (0,0) with frame_start=1.
- Override CLK_DIV=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, SYNC_POL=1 -> pix_en stays 1. Line is 16 clks, with hsync high for coord_x=10..12. Frame is 128 clks, with vsync high for coord_y=5.
